// File: rtl/ring_seq_checker_pkg.sv
// ring_seq_pkg: shared phase constants, lock-state type and the expected-x
// helper for the ring sequencer receive-side checker.
//   PH0..PH3      phase index constants
//   lock_state_t  lock FSM states (HUNT, LOCKED, FAULT)
//   exp_x()       x value the sender drives in a given phase
package ring_seq_pkg;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } lock_state_t;

    // The sender's x is the parity of its phase: 1 in phases 0/2, 0 in 1/3.
    function automatic logic exp_x(input logic [1:0] phase);
        return ~phase[0];
    endfunction

endpackage

// File: rtl/ring_seq_checker_if.sv
// ring_seq_checker_if: groups the monitor-facing signals of ring_seq_checker.
//   a, x_obs, clr_err          : observed strobe, observed x, error-count clear
//   phase, locked, fault       : tracker status
//   err_pulse, err_cnt         : error reporting
//   dbg_state                  : current lock FSM state, for checkers
// Signalling: there is no handshake or backpressure. Every input is sampled on
// every rising clk edge, and every output is a registered level that is valid
// for the whole cycle after the edge that produced it.
// modport master: the side that drives the observations (bench / wrapper).
// modport slave : the checker itself.
interface ring_seq_checker_if #(
    parameter int ERR_W = 8
);
    import ring_seq_pkg::*;

    logic             a;
    logic             x_obs;
    logic             clr_err;
    logic [1:0]       phase;
    logic             locked;
    logic             fault;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    lock_state_t      dbg_state;

    modport master (
        output a, x_obs, clr_err,
        input  phase, locked, fault, err_pulse, err_cnt, dbg_state
    );

    modport slave (
        input  a, x_obs, clr_err,
        output phase, locked, fault, err_pulse, err_cnt, dbg_state
    );

endinterface

// File: rtl/ring_seq_checker_sat_counter.sv
// sat_counter: W-bit up-counter that saturates at all-ones.
//   clk, rstn : clock, synchronous active-low reset (clears to 0)
//   inc       : add one this cycle (ignored once at all-ones)
//   clr       : clear to 0; wins over inc
//   q         : registered count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/ring_seq_checker.sv
// ring_seq_checker: receive-side tracker for the 4-phase ring sequencer.
// Mirrors the sender's phase from the shared advance strobe, compares the
// observed x each cycle, acquires lock and counts sequence errors.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : ring_seq_checker_if.slave
//               in : a, x_obs, clr_err
//               out: phase, locked, fault, err_pulse, err_cnt, dbg_state
// Only parity is observable, so after a realign the phase is correct mod 2;
// it is exact when the sender leaves reset on the same edge.
module ring_seq_checker
    import ring_seq_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic                clk,
    input  logic                rstn,
    ring_seq_checker_if.slave   bus
);

    // run only has to reach LOCK_CNT-1.
    localparam int RUN_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

    lock_state_t      state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic             err_pulse_q, err_pulse_d;

    logic             mis;
    logic             err_event;
    logic             run_inc;
    logic             run_clr;
    logic             run_done;
    logic [RUN_W-1:0] run_q;
    logic [ERR_W-1:0] err_cnt_w;

    assign mis      = (bus.x_obs != exp_x(phase_q));
    assign run_done = (run_q == RUN_W'(LOCK_CNT - 1));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q + {1'b0, bus.a};
        err_event   = 1'b0;
        run_inc     = 1'b0;
        run_clr     = 1'b1;

        case (state_q)
            HUNT: begin
                if (mis) begin
                    // Flip parity before applying the advance so the
                    // tracker lines up with what was just observed.
                    phase_d = (phase_q ^ 2'b01) + {1'b0, bus.a};
                end else if (run_done) begin
                    state_d = LOCKED;
                end else begin
                    run_inc = 1'b1;
                    run_clr = 1'b0;
                end
            end
            LOCKED: begin
                if (mis) begin
                    state_d   = FAULT;
                    err_event = 1'b1;
                end
            end
            FAULT: begin
                if (mis) begin
                    state_d   = HUNT;
                    phase_d   = (phase_q ^ 2'b01) + {1'b0, bus.a};
                    err_event = 1'b1;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        err_pulse_d = err_event;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= HUNT;
            phase_q     <= PH0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (run_inc),
        .clr  (run_clr),
        .q    (run_q)
    );

    // clr_err beats a same-cycle error; the pulse still reports that error.
    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (err_event),
        .clr  (bus.clr_err),
        .q    (err_cnt_w)
    );

    assign bus.phase     = phase_q;
    assign bus.locked    = (state_q == LOCKED);
    assign bus.fault     = (state_q == FAULT);
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_w;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ring_seq_checker.sv
// tb_ring_seq_checker: drives two checker instances with the same stimulus
//   dut0: LOCK_CNT=4, ERR_W=8
//   dut1: LOCK_CNT=1, ERR_W=2 (first-match lock, early saturation)
// A golden sender phase produces x_obs; the reference model follows the
// tracker rules with plain integers.
module tb_ring_seq_checker;

    logic clk;
    logic rstn;

    ring_seq_checker_if #(.ERR_W(8)) bus0 ();
    ring_seq_checker_if #(.ERR_W(2)) bus1 ();

    ring_seq_checker #(.LOCK_CNT(4), .ERR_W(8)) dut0 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus0.slave)
    );

    ring_seq_checker #(.LOCK_CNT(1), .ERR_W(2)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = hunting, 1 = locked, 2 = fault
    int s_phase;                 // golden sender phase
    int m_phase[2];
    int m_mode[2];
    int m_run[2];
    int m_cnt[2];
    int m_pulse[2];
    int lock_n[2] = '{4, 1};
    int cnt_max[2] = '{255, 3};

    task automatic model_step(input int k, input bit r, input bit a_i, input bit x_i, input bit c_i);
        int ph;
        bit expect_x;
        bit mis;
        bit err;
        if (!r) begin
            m_phase[k] = 0; m_mode[k] = 0; m_run[k] = 0; m_cnt[k] = 0; m_pulse[k] = 0;
            return;
        end
        expect_x = (m_phase[k] % 2 == 0);
        mis = (x_i != expect_x);
        err = 1'b0;
        ph = m_phase[k];
        if (m_mode[k] == 0) begin
            if (mis) begin
                ph = (ph % 2 == 0) ? ph + 1 : ph - 1;
                m_run[k] = 0;
            end else if (m_run[k] + 1 == lock_n[k]) begin
                m_mode[k] = 1;
                m_run[k] = 0;
            end else begin
                m_run[k]++;
            end
        end else if (m_mode[k] == 1) begin
            if (mis) begin
                m_mode[k] = 2;
                err = 1'b1;
            end
        end else begin
            if (mis) begin
                m_mode[k] = 0;
                m_run[k] = 0;
                ph = (ph % 2 == 0) ? ph + 1 : ph - 1;
                err = 1'b1;
            end else begin
                m_mode[k] = 1;
            end
        end
        m_phase[k] = (ph + a_i) % 4;
        m_pulse[k] = err;
        if (c_i) m_cnt[k] = 0;
        else if (err && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive inputs, predict, clock, compare.
    task automatic step(input bit r, input bit a_i, input bit flip, input bit c_i);
        bit x_i;
        x_i = (s_phase % 2 == 0) ^ flip;
        rstn = r;
        bus0.a = a_i; bus0.x_obs = x_i; bus0.clr_err = c_i;
        bus1.a = a_i; bus1.x_obs = x_i; bus1.clr_err = c_i;
        for (int k = 0; k < 2; k++) begin
            model_step(k, r, a_i, x_i, c_i);
            exp_q.push_back(m_phase[k]);
            exp_q.push_back(m_mode[k] == 1);
            exp_q.push_back(m_mode[k] == 2);
            exp_q.push_back(m_pulse[k]);
            exp_q.push_back(m_cnt[k]);
        end
        s_phase = r ? (s_phase + a_i) % 4 : 0;
        @(posedge clk);
        #1;
        check_eq("dut0_phase",     32'(bus0.phase),     exp_q.pop_front());
        check_eq("dut0_locked",    32'(bus0.locked),    exp_q.pop_front());
        check_eq("dut0_fault",     32'(bus0.fault),     exp_q.pop_front());
        check_eq("dut0_err_pulse", 32'(bus0.err_pulse), exp_q.pop_front());
        check_eq("dut0_err_cnt",   32'(bus0.err_cnt),   exp_q.pop_front());
        check_eq("dut1_phase",     32'(bus1.phase),     exp_q.pop_front());
        check_eq("dut1_locked",    32'(bus1.locked),    exp_q.pop_front());
        check_eq("dut1_fault",     32'(bus1.fault),     exp_q.pop_front());
        check_eq("dut1_err_pulse", 32'(bus1.err_pulse), exp_q.pop_front());
        check_eq("dut1_err_cnt",   32'(bus1.err_cnt),   exp_q.pop_front());
    endtask

    task automatic do_reset();
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic golden(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        s_phase = 0;
        rstn = 1'b0;
        bus0.a = 1'b0; bus0.x_obs = 1'b0; bus0.clr_err = 1'b0;
        bus1.a = 1'b0; bus1.x_obs = 1'b0; bus1.clr_err = 1'b0;
        @(posedge clk);
        #1;

        // 1: golden sequence, lock after 4 matches
        do_reset();
        check_eq("t1_reset_locked", 32'(bus0.locked), 32'd0);
        check_eq("t1_reset_phase",  32'(bus0.phase),  32'd0);
        golden(3);
        check_eq("t1_not_yet_locked", 32'(bus0.locked), 32'd0);
        golden(1);
        check_eq("t1_locked_4th", 32'(bus0.locked), 32'd1);
        golden(4);

        // 2: inverted x from cycle 0, realign then lock after 1+4
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t2_locked", 32'(bus0.locked), 32'd1);
        check_eq("t2_err_cnt", 32'(bus0.err_cnt), 32'd0);

        // 3: single flip while locked
        do_reset();
        golden(6);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t3_fault", 32'(bus0.fault), 32'd1);
        check_eq("t3_pulse", 32'(bus0.err_pulse), 32'd1);
        golden(1);
        check_eq("t3_relocked", 32'(bus0.locked), 32'd1);
        check_eq("t3_err_cnt", 32'(bus0.err_cnt), 32'd1);

        // 4: two consecutive flips -> back to hunting, then relock
        do_reset();
        golden(6);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t4_hunt", 32'(bus0.locked), 32'd0);
        check_eq("t4_err_cnt", 32'(bus0.err_cnt), 32'd2);
        golden(6);
        check_eq("t4_relocked", 32'(bus0.locked), 32'd1);

        // 5: saturation of the 2-bit counter, clear beats concurrent error
        do_reset();
        golden(6);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            golden(3);
        end
        check_eq("t5_sat", 32'(bus1.err_cnt), 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("t5_clr_cnt", 32'(bus1.err_cnt), 32'd0);
        check_eq("t5_clr_pulse", 32'(bus1.err_pulse), 32'd1);
        golden(2);

        // 6: reset while locked at phase 3
        do_reset();
        golden(7);
        check_eq("t6_pre_phase", 32'(bus0.phase), 32'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t6_phase", 32'(bus0.phase), 32'd0);
        check_eq("t6_locked", 32'(bus0.locked), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 31) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
